// File: rtl/bank_write_scheduler.sv
// Skewed-bank write scheduler: maps lane (row,col) to (bank,entry),
// issues non-colliding lanes together and serializes collisions.
// Ports: clk/reset; in_valid/in_ready/in_mask/in_row/in_col/in_data
// batch input; stall from buffer; wr_en/wr_entry/wr_data registered
// per-bank writes; batch_done pulse; busy while lanes are pending.
module bank_write_scheduler #(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256,
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ENTRY_W   = $clog2(TILE_SIZE),
  localparam int BANK_W    = $clog2(BANK_COUNT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_mask,
  input  logic [LANES*ENTRY_W-1:0]      in_row,
  input  logic [LANES*BANK_W-1:0]       in_col,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          stall,
  output logic [BANK_COUNT-1:0]         wr_en,
  output logic [BANK_COUNT*ENTRY_W-1:0] wr_entry,
  output logic [BANK_COUNT*DATA_WIDTH-1:0] wr_data,
  output logic                          batch_done,
  output logic                          busy
);

  logic [LANES-1:0]      pend_q, pend_d;
  logic [BANK_W-1:0]     bank_q  [LANES];
  logic [ENTRY_W-1:0]    entry_q [LANES];
  logic [DATA_WIDTH-1:0] data_q  [LANES];
  logic [BANK_W-1:0]     in_bank [LANES];

  logic [BANK_COUNT-1:0]            wr_en_q, wr_en_d;
  logic [BANK_COUNT*ENTRY_W-1:0]    wr_entry_q, wr_entry_d;
  logic [BANK_COUNT*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic done_q, done_d;

  logic [LANES-1:0] grant;
  logic [LANES-1:0] left;
  logic             accept;

  // (3*row) mod BANK_COUNT only needs the low bank bits of row.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic [BANK_W-1:0] rlo;
      rlo = BANK_W'(in_row[i*ENTRY_W +: ENTRY_W]);
      in_bank[i] = in_col[i*BANK_W +: BANK_W]
                 + rlo + (rlo << 1);
    end
  end

  // Lowest pending lane wins each bank.
  always_comb begin
    grant = '0;
    for (int i = 0; i < LANES; i++) begin
      grant[i] = pend_q[i] & ~stall;
      for (int j = 0; j < i; j++) begin
        if (pend_q[j] && bank_q[j] == bank_q[i])
          grant[i] = 1'b0;
      end
    end
  end

  assign left     = pend_q & ~grant;
  assign in_ready = !stall && (left == '0);
  assign accept   = in_valid && in_ready;
  assign pend_d   = accept ? in_mask : left;
  assign done_d   = (|pend_q) && (left == '0);
  assign busy     = |pend_q;

  always_comb begin
    wr_en_d    = '0;
    wr_entry_d = wr_entry_q;
    wr_data_d  = wr_data_q;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) begin
        wr_en_d[bank_q[i]] = 1'b1;
        wr_entry_d[int'(bank_q[i])*ENTRY_W +: ENTRY_W]
          = entry_q[i];
        wr_data_d[int'(bank_q[i])*DATA_WIDTH +: DATA_WIDTH]
          = data_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      wr_en_q    <= '0;
      wr_entry_q <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      wr_en_q    <= wr_en_d;
      wr_entry_q <= wr_entry_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  // Lane payload is only meaningful while pending, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        bank_q[i]  <= in_bank[i];
        entry_q[i] <= in_row[i*ENTRY_W +: ENTRY_W];
        data_q[i]  <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_entry   = wr_entry_q;
  assign wr_data    = wr_data_q;
  assign batch_done = done_q;

endmodule

// File: doc/bank_write_scheduler.md
# bank_write_scheduler

Write-side counterpart of the tile bank addressing: takes a batch of up to LANES (row, column, data) elements per cycle and converts each to (bank, entry) using the skewed mapping bank = (column + 3·row) mod BANK_COUNT, entry = row. Lanes that target distinct banks are written in the same cycle. Lanes that collide on one bank are serialized across cycles, with back-pressure applied to the producer. It sits between the output-tile producer and the banked tile buffer. Its addressing is the exact inverse of the buffer's read-side (bank, entry) → (row, column) translation.

## Interface
- BANK_COUNT, 32, number of buffer banks; must be a power of two
- TILE_SIZE, 256, entries per bank; ENTRY_W = $clog2(TILE_SIZE)
- LANES, 4, elements per input batch
- DATA_WIDTH, 8, element width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  batch valid
- in_ready  out  1  batch accepted on a clk edge when in_valid && in_ready
- in_mask  in  LANES  per-lane valid
- in_row  in  LANES·ENTRY_W  lane i at bits [i·ENTRY_W +: ENTRY_W]
- in_col  in  LANES·$clog2(BANK_COUNT)  lane column
- in_data  in  LANES·DATA_WIDTH  lane data
- stall  in  1  buffer cannot accept writes this cycle
- wr_en  out  BANK_COUNT  per-bank write strobe, registered
- wr_entry  out  BANK_COUNT·ENTRY_W  per-bank entry, registered
- wr_data  out  BANK_COUNT·DATA_WIDTH  per-bank data, registered
- batch_done  out  1  registered pulse when the last pending lane of a batch is written
- busy  out  1  pending lanes exist

## Operation
- On accept, register per lane: pending[i] = in_mask[i], bank[i], entry[i] = in_row[i], data[i].
- bank[i] = (in_col[i] + ((in_row[i]·3) mod BANK_COUNT)) mod BANK_COUNT. Use the low $clog2(BANK_COUNT) bits of the sum, so overflow wraps.
- Grant, combinational, evaluated every cycle with stall=0: grant[i] = pending[i] and no j<i with pending[j] and bank[j]==bank[i]. The lowest lane wins each bank.
- For each granted lane, on the next edge: wr_en[bank[i]]=1, wr_entry/wr_data slices of that bank are loaded, and pending[i] is cleared. Banks with no grant get wr_en=0. Entry and data slices of non-written banks hold their values.
- With stall=1: no grants, wr_en=0 on the next edge, pending unchanged.
- in_ready = !stall && ((pending & ~grant) == 0). A batch is accepted in the same cycle the previous one issues its final lanes.
- batch_done is set on the edge where pending goes from non-zero to zero.
- busy = |pending.
- Accept with in_mask=0: accepted, no writes, no batch_done.
- Duplicate (row, col) in one batch: same bank, so the lanes serialize in lane order. The highest lane's data is written last and wins.
- reset: clears pending, wr_en, wr_entry, wr_data, batch_done to 0. Any in-flight batch is discarded with no further writes. in_ready reads 1 in the first cycle after reset if stall=0.

## Timing
- Batch accepted at edge E0. First wr_en is visible after edge E1, i.e. 2 cycles from in_valid to write strobe.
- Conflict-free batch: all lanes written at E1. in_ready stays high, giving a throughput of 1 batch per cycle.
- A batch whose worst bank has k colliding lanes takes k issue cycles. in_ready is low for k−1 cycles, plus any stall cycles.
- A stall cycle delays issue by exactly one cycle. No lane is lost or duplicated.
- Outputs depend only on registers. in_ready depends combinationally on state and stall only, never on in_valid.

## Test plan
- Mapping, defaults, stall=0: one batch. Lane0 (row1, col0) → wr_en[3], entry 1. Lane1 (row11, col0) → bank 1 (33 wraps), entry 11. Lane2 (row10, col2) → bank 0 (32 wraps). Lane3 (row0, col31) → bank 31. All four writes land on the same edge, 2 cycles after accept, with one batch_done pulse.
- Conflict: lanes (row0, col3), (row1, col0), (row0, col4), mask 4'b0111. Lanes 0 and 1 both map to bank 3. Cycle 1 writes banks 3 (lane0 data) and 4. Cycle 2 writes bank 3 (lane1 data). in_ready is low for exactly 1 cycle. batch_done follows cycle 2.
- Back-to-back: 8 consecutive conflict-free batches with in_valid held high. in_ready never drops, one batch is written per cycle, and batch_done pulses 8 times.
- Stall: assert stall for 3 cycles mid-batch on the 4-way-conflict batch (all lanes bank 5). Exactly 4 writes to bank 5 occur in lane order, none during stall, and in_ready is low throughout.
- Reset mid-operation: assert reset while 2 lanes are pending. The next cycle shows wr_en=0 and busy=0, and no residual writes follow. A new batch then behaves as in the first scenario.
- Duplicate address: all 4 lanes (row7, col2), data 1..4. Bank 23 is written 4 times, entry 7, with final data 4.
